parity_serial_rx: RTL

- Receive side of the team's byte-parity link: deserialises a start/8-data/parity/stop frame and recomputes XOR parity over the received byte.
- Flags parity and framing errors.
- Sits at the far end of the link, downstream of the transmitter that appends the reduction-XOR parity bit.
- Bit timing comes from an external per-bit strobe, so there is no baud generator inside.

---
 rtl/parity_serial_rx.sv | 100 ++++++++++
 1 files changed

// File: rtl/parity_serial_rx.sv
// Receiver for the byte-parity link: start / 8 data (LSB first) / parity / stop, sampled on bit_en.
// Optional saturating parity-error counter is enabled by defining PARITY_ERR_CNT_EN.
module parity_serial_rx #(
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             rx,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       pbit_q;
  logic       exp_par;

  assign exp_par = (^shift_q) ^ PARITY_ODD;
  assign busy    = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      pbit_q     <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_en) begin
        unique case (state_q)
          StIdle: begin
            if (!rx) begin
              state_q   <= StData;
              bit_cnt_q <= 3'd0;
            end
          end
          StData: begin
            shift_q[bit_cnt_q] <= rx;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            pbit_q  <= rx;
            state_q <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            // A bad stop bit discards both the byte and its parity result.
            if (rx) begin
              data_out   <= shift_q;
              data_valid <= 1'b1;
              parity_err <= (pbit_q != exp_par);
            end else begin
              frame_err  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      // Clear wins over the count, but a coincident error is not lost.
      cnt_q <= parity_err ? CNT_W'(1) : '0;
    end else if (parity_err && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign err_count      = '0;
`endif

endmodule
